reg_file_32: RTL

32-entry x 32-bit register file directly upstream of alu_32; its two read ports drive the ALU `a` and `b` operands.
Writeback of the ALU result `out_resultado` returns through the single write port.
Also holds a 3-bit status register that captures the ALU `zero`, `carry_out` and `overflow` flags on request.
Register 0 is hardwired to zero (MIPS convention, matching the alu_control encoding used by the ALU).

---
 rtl/reg_file_32.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_file_32.sv
// ============================================================================
// reg_file_32 : 32x32 register file with hardwired r0, optional write-to-read
//               forwarding, captured ALU status flags and a commit counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file_32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              ovf_in,
  output logic [2:0]        flags,
  output logic [15:0]       write_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] w_entry [DEPTH];
  logic              w_commit;
  logic [DATA_W-1:0] w_stored_a;
  logic [DATA_W-1:0] w_stored_b;
  logic [2:0]        r_flags;
  logic [15:0]       r_write_count;

  // Gating with reset keeps forwarded data from leaking out while in reset.
  assign w_commit = wr_en && (wr_addr != '0) && !reset;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi == 0) begin : g_zero
      assign w_entry[gi] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_q <= '0;
        end else if (w_commit && (wr_addr == ADDR_W'(gi))) begin
          r_q <= wr_data;
        end
      end
      assign w_entry[gi] = r_q;
    end
  end

  assign w_stored_a = w_entry[rd_addr_a];
  assign w_stored_b = w_entry[rd_addr_b];

  if (BYPASS != 0) begin : g_bypass
    assign rd_data_a = (w_commit && (wr_addr == rd_addr_a)) ? wr_data : w_stored_a;
    assign rd_data_b = (w_commit && (wr_addr == rd_addr_b)) ? wr_data : w_stored_b;
  end else begin : g_no_bypass
    assign rd_data_a = w_stored_a;
    assign rd_data_b = w_stored_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 3'b000;
    end else if (flag_we) begin
      r_flags <= {ovf_in, carry_in, zero_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_count <= 16'h0000;
    end else if (w_commit) begin
      r_write_count <= r_write_count + 16'h0001;
    end
  end

  assign flags       = r_flags;
  assign write_count = r_write_count;

endmodule

`default_nettype wire
